// File: rtl/sram_port_arb.sv
// Arbiter/sequencer for the shared IFU/LSU single-port SRAM.
// Define SRAM_ARB_STARVE_GUARD_EN to bound IFU starvation.
module sram_port_arb #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_req_addr,
    output logic              ifu_rsp_valid,
    input  logic              ifu_rsp_ready,
    output logic [DATA_W-1:0] ifu_rsp_rdata,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_req_addr,
    input  logic              lsu_req_write,
    input  logic [DATA_W-1:0] lsu_req_wdata,
    input  logic [DATA_W/8-1:0] lsu_req_wmask,
    output logic              lsu_rsp_valid,
    input  logic              lsu_rsp_ready,
    output logic [DATA_W-1:0] lsu_rsp_rdata,
    output logic              sram_cs,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    output logic [DATA_W/8-1:0] sram_wem,
    input  logic [DATA_W-1:0] sram_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        RSP,
        HOLD
    } state_e;

    state_e            state_q, state_d;
    logic              own_lsu_q, own_lsu_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] hold_q, hold_d;

    logic              rsp_act;
    logic              rsp_fire;
    logic              can_grant;
    logic              sel_ifu;
    logic              force_ifu;
    logic              gnt_ifu;
    logic              gnt_lsu;
    logic [DATA_W-1:0] rsp_data;

    always_comb begin
        rsp_act  = (state_q != IDLE);
        rsp_data = hold_q;
        if (state_q == RSP) begin
            rsp_data = wr_q ? '0 : sram_rdata;
        end
    end

    assign ifu_rsp_valid = rsp_act & ~own_lsu_q;
    assign lsu_rsp_valid = rsp_act & own_lsu_q;
    assign ifu_rsp_rdata = ifu_rsp_valid ? rsp_data : '0;
    assign lsu_rsp_rdata = lsu_rsp_valid ? rsp_data : '0;

    assign rsp_fire = own_lsu_q ? (lsu_rsp_valid & lsu_rsp_ready)
                                : (ifu_rsp_valid & ifu_rsp_ready);

    // Gating with rst_n keeps every ready/command low while reset is held.
    assign can_grant = rst_n & (~rsp_act | rsp_fire);

`ifdef SRAM_ARB_STARVE_GUARD_EN
    logic [3:0] starve_q, starve_d;

    assign force_ifu = ifu_req_valid & (starve_q == 4'(STARVE_MAX));

    always_comb begin
        starve_d = starve_q;
        if (!ifu_req_valid || gnt_ifu) begin
            starve_d = '0;
        end else if (gnt_lsu && starve_q != 4'hF) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign force_ifu = 1'b0;
`endif

    assign sel_ifu       = force_ifu | ~lsu_req_valid;
    assign ifu_req_ready = can_grant & sel_ifu;
    assign lsu_req_ready = can_grant & ~sel_ifu;
    assign gnt_ifu       = ifu_req_ready & ifu_req_valid;
    assign gnt_lsu       = lsu_req_ready & lsu_req_valid;

    always_comb begin
        sram_cs    = gnt_ifu | gnt_lsu;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        sram_wem   = '0;
        if (gnt_lsu) begin
            sram_we    = lsu_req_write;
            sram_addr  = lsu_req_addr;
            sram_wdata = lsu_req_wdata;
            sram_wem   = lsu_req_write ? lsu_req_wmask : '0;
        end else if (gnt_ifu) begin
            sram_addr = ifu_req_addr;
        end
    end

    always_comb begin
        state_d   = state_q;
        own_lsu_d = own_lsu_q;
        wr_d      = wr_q;
        hold_d    = hold_q;
        if (gnt_ifu || gnt_lsu) begin
            state_d   = RSP;
            own_lsu_d = gnt_lsu;
            wr_d      = gnt_lsu & lsu_req_write;
        end else if (rsp_fire) begin
            state_d = IDLE;
        end else if (state_q == RSP) begin
            state_d = HOLD;
            hold_d  = rsp_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            own_lsu_q <= 1'b0;
            wr_q      <= 1'b0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            own_lsu_q <= own_lsu_d;
            wr_q      <= wr_d;
            hold_q    <= hold_d;
        end
    end

endmodule

// File: tb/tb_sram_port_arb.sv
// Directed bench for sram_port_arb with an SRAM model and response scoreboard.
// Honours SRAM_ARB_STARVE_GUARD_EN for the starvation grant pattern.
module tb_sram_port_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ifu_req_valid, ifu_req_ready;
    logic [15:0] ifu_req_addr;
    logic        ifu_rsp_valid, ifu_rsp_ready;
    logic [31:0] ifu_rsp_rdata;
    logic        lsu_req_valid, lsu_req_ready;
    logic [15:0] lsu_req_addr;
    logic        lsu_req_write;
    logic [31:0] lsu_req_wdata;
    logic [3:0]  lsu_req_wmask;
    logic        lsu_rsp_valid, lsu_rsp_ready;
    logic [31:0] lsu_rsp_rdata;
    logic        sram_cs, sram_we;
    logic [15:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [3:0]  sram_wem;
    logic [31:0] sram_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem  [256];
    logic [31:0] refm [256];
    logic [31:0] rd_q;
    logic        force_rd;
    logic [31:0] force_val;
    logic [31:0] iq [$];
    logic [31:0] lq [$];

    always #5 clk = ~clk;

    sram_port_arb #(.ADDR_W(16), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_req_addr(ifu_req_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready),
        .ifu_rsp_rdata(ifu_rsp_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_req_addr(lsu_req_addr), .lsu_req_write(lsu_req_write),
        .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready),
        .lsu_rsp_rdata(lsu_rsp_rdata),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_wem(sram_wem),
        .sram_rdata(sram_rdata)
    );

    function automatic logic [31:0] merge(input logic [31:0] o,
                                          input logic [31:0] n,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++)
            if (m[b]) r[b*8 +: 8] = n[b*8 +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (sram_cs) begin
            if (sram_we)
                mem[sram_addr[7:0]] <= merge(mem[sram_addr[7:0]], sram_wdata, sram_wem);
            else
                rd_q <= mem[sram_addr[7:0]];
        end
    end

    assign sram_rdata = force_rd ? force_val : rd_q;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: pushes on request handshakes, pops on response handshakes.
    task automatic monitor();
        logic gi, gl;
        logic [31:0] e;
        gi = ifu_req_valid & ifu_req_ready;
        gl = lsu_req_valid & lsu_req_ready;
        check("cs_vs_grant", sram_cs, gi | gl);
        check("one_rsp_owner", ifu_rsp_valid & lsu_rsp_valid, 0);
        if (ifu_rsp_valid && ifu_rsp_ready) begin
            if (iq.size() == 0) check("ifu_spurious_rsp", 1, 0);
            else begin
                e = iq.pop_front();
                check("ifu_rsp_data", ifu_rsp_rdata, e);
            end
        end
        if (lsu_rsp_valid && lsu_rsp_ready) begin
            if (lq.size() == 0) check("lsu_spurious_rsp", 1, 0);
            else begin
                e = lq.pop_front();
                check("lsu_rsp_data", lsu_rsp_rdata, e);
            end
        end
        if (gl) begin
            check("lsu_sram_addr", sram_addr, lsu_req_addr);
            if (lsu_req_write) begin
                lq.push_back(32'h0);
                refm[lsu_req_addr[7:0]] = merge(refm[lsu_req_addr[7:0]],
                                                lsu_req_wdata, lsu_req_wmask);
            end else begin
                lq.push_back(refm[lsu_req_addr[7:0]]);
            end
        end else if (gi) begin
            check("ifu_sram_addr", sram_addr, ifu_req_addr);
            iq.push_back(refm[ifu_req_addr[7:0]]);
        end
    endtask

    task automatic settle();
        #3;
        monitor();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        settle();
        adv();
    endtask

    task automatic idle_inputs();
        ifu_req_valid = 0;
        lsu_req_valid = 0;
        lsu_req_write = 0;
        lsu_req_wdata = 0;
        lsu_req_wmask = 0;
    endtask

    initial begin
        bit exp_ifu;
        for (int i = 0; i < 256; i++) begin
            mem[i]  = {i[7:0], ~i[7:0], 8'h5A, i[7:0]};
            refm[i] = {i[7:0], ~i[7:0], 8'h5A, i[7:0]};
        end
        mem[16'h10]  = 32'h00100093;
        refm[16'h10] = 32'h00100093;
        rd_q = 0;
        force_rd = 0;
        force_val = 0;
        ifu_rsp_ready = 1;
        lsu_rsp_ready = 1;
        idle_inputs();
        ifu_req_addr = 16'h0010;
        lsu_req_addr = 16'h0030;

        // reset with both requesters valid
        rst_n = 0;
        ifu_req_valid = 1;
        lsu_req_valid = 1;
        #3;
        check("rst_ifu_req_ready", ifu_req_ready, 0);
        check("rst_lsu_req_ready", lsu_req_ready, 0);
        check("rst_ifu_rsp_valid", ifu_rsp_valid, 0);
        check("rst_lsu_rsp_valid", lsu_rsp_valid, 0);
        check("rst_sram_cmd", {sram_cs, sram_we, sram_addr, sram_wem}, 0);
        check("rst_sram_wdata", sram_wdata, 0);
        check("rst_rdata", {ifu_rsp_rdata, lsu_rsp_rdata}, 0);
        adv();
        rst_n = 1;
        settle();
        check("rel_lsu_wins", lsu_req_ready, 1);
        check("rel_ifu_blocked", ifu_req_ready, 0);
        check("rel_cs", sram_cs, 1);
        check("rel_we", sram_we, 0);
        adv();
        idle_inputs();
        settle();
        check("rel_lsu_rsp_valid", lsu_rsp_valid, 1);
        adv();
        step();

        // IFU read, back-to-back
        ifu_req_valid = 1;
        ifu_req_addr = 16'h0010;
        settle();
        check("ifu_ready_N", ifu_req_ready, 1);
        check("ifu_we_N", {sram_we, sram_wem}, 0);
        check("ifu_wdata_N", sram_wdata, 0);
        adv();
        ifu_req_addr = 16'h0011;
        settle();
        check("ifu_rsp_valid_N1", ifu_rsp_valid, 1);
        check("ifu_rdata_N1", ifu_rsp_rdata, 32'h00100093);
        check("ifu_ready_N1", ifu_req_ready, 1);
        check("lsu_rsp_valid_idle", lsu_rsp_valid, 0);
        adv();
        idle_inputs();
        step();
        step();

        // LSU byte-masked write then readback
        lsu_req_valid = 1;
        lsu_req_addr = 16'h0020;
        lsu_req_write = 1;
        lsu_req_wdata = 32'hDEADBEEF;
        lsu_req_wmask = 4'b0011;
        settle();
        check("wr_ready", lsu_req_ready, 1);
        check("wr_we", sram_we, 1);
        check("wr_wem", sram_wem, 4'b0011);
        check("wr_wdata", sram_wdata, 32'hDEADBEEF);
        adv();
        lsu_req_write = 0;
        lsu_req_wmask = 0;
        settle();
        check("wr_rsp_valid", lsu_rsp_valid, 1);
        check("wr_rsp_zero", lsu_rsp_rdata, 0);
        check("rd_wem_zero", sram_wem, 0);
        adv();
        idle_inputs();
        step();
        step();

        // IFU response stall
        ifu_rsp_ready = 0;
        ifu_req_valid = 1;
        ifu_req_addr = 16'h0010;
        settle();
        check("stall_grant", ifu_req_ready, 1);
        adv();
        ifu_req_valid = 0;
        lsu_req_valid = 1;
        lsu_req_addr = 16'h0030;
        for (int k = 0; k < 3; k++) begin
            settle();
            check("stall_valid", ifu_rsp_valid, 1);
            check("stall_rdata", ifu_rsp_rdata, 32'h00100093);
            check("stall_lsu_ready", lsu_req_ready, 0);
            check("stall_no_cs", sram_cs, 0);
            adv();
            force_rd = 1;
            force_val = 32'h12345678;
        end
        ifu_rsp_ready = 1;
        settle();
        check("fire_lsu_ready", lsu_req_ready, 1);
        check("fire_cs", sram_cs, 1);
        adv();
        force_rd = 0;
        idle_inputs();
        step();
        step();

        // both valid continuously
        ifu_req_valid = 1;
        lsu_req_valid = 1;
        ifu_req_addr = 16'h0010;
        lsu_req_addr = 16'h0030;
        for (int i = 0; i < 10; i++) begin
`ifdef SRAM_ARB_STARVE_GUARD_EN
            exp_ifu = (i % 5 == 4);
`else
            exp_ifu = 0;
`endif
            settle();
            check("starve_ifu_ready", ifu_req_ready, exp_ifu);
            check("starve_lsu_ready", lsu_req_ready, !exp_ifu);
            adv();
        end
        idle_inputs();
        step();
        step();

        // reset while a response is outstanding
        lsu_req_valid = 1;
        lsu_req_addr = 16'h0040;
        step();
        idle_inputs();
        #1;
        check("pre_rst_valid", lsu_rsp_valid, 1);
        rst_n = 0;
        #1;
        check("async_rst_valid", lsu_rsp_valid, 0);
        check("async_rst_rdata", lsu_rsp_rdata, 0);
        lq.delete();
        iq.delete();
        adv();
        rst_n = 1;
        for (int k = 0; k < 3; k++) begin
            settle();
            check("post_rst_no_rsp", {ifu_rsp_valid, lsu_rsp_valid}, 0);
            adv();
        end

        check("ifu_queue_empty", iq.size(), 0);
        check("lsu_queue_empty", lq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
